// File: rtl/dino_pkg.sv
// Shared types and default constants for the Dino Run game sequencer.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_t;

  localparam int DEF_TICK_DIV       = 2_000_000;
  localparam int DEF_PASS_PER_LEVEL = 12;
  localparam int DEF_SPEED_INIT     = 1;
  localparam int DEF_SPEED_MAX      = 15;
  localparam int DEF_HIT_CYCLES     = 25_000_000;
  localparam int SCORE_DIGITS       = 5;
  localparam int SPEED_W            = 11;

endpackage

// File: rtl/dino_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; wraps from all-nines to zero.
module dino_bcd_counter #(
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                inc,
  output logic [4*DIGITS-1:0] value
);

  logic [4*DIGITS-1:0] value_d;
  logic                carry;
  logic [3:0]          nib;

  // Ripple the +1 through the digits; a 9 with carry-in becomes 0 and passes the carry on.
  always_comb begin
    value_d = value;
    carry   = inc;
    nib     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = value[4*i +: 4];
      if (carry) begin
        if (nib == 4'd9) begin
          value_d[4*i +: 4] = 4'd0;
        end else begin
          value_d[4*i +: 4] = nib + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // Score register; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else begin
      value <= value_d;
    end
  end

endmodule

// File: rtl/dino_game_ctrl.sv
// Dino Run game sequencer: game FSM, motion tick, speed ramp, BCD score, start edge detect.
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int PASS_PER_LEVEL = DEF_PASS_PER_LEVEL,
  parameter int SPEED_INIT     = DEF_SPEED_INIT,
  parameter int SPEED_MAX      = DEF_SPEED_MAX,
  parameter int HIT_CYCLES     = DEF_HIT_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      btn_start,
  input  logic                      collision,
  input  logic                      obstacle_wrap,
  output logic                      tick,
  output logic [SPEED_W-1:0]        speed,
  output logic [1:0]                anim_phase,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [1:0]                state,
  output logic                      game_over,
  output logic                      clear_obstacles
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HIT_CYCLES + 1);
  localparam int PW = (PASS_PER_LEVEL > 1) ? $clog2(PASS_PER_LEVEL) : 1;
  localparam logic [SPEED_W-1:0] SPEED_INIT_V = SPEED_W'(SPEED_INIT);
  localparam logic [SPEED_W-1:0] SPEED_MAX_V  = SPEED_W'(SPEED_MAX);

  game_state_t        state_q, state_d;
  logic               btn_q;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [HW-1:0]      hit_cnt_q, hit_cnt_d;
  logic [PW-1:0]      pass_q, pass_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [1:0]         anim_q, anim_d;
  logic               tick_q, clr_q, over_q;

  logic start_edge, restart, tick_fire, hit_done;

  assign start_edge = btn_start & ~btn_q;
  assign restart    = start_edge && (state_q == IDLE || state_q == OVER);
  // Collision suppresses the tick and freezes the divider in the same cycle.
  assign tick_fire  = (state_q == RUN) && !collision && (tick_cnt_q == TW'(TICK_DIV - 1));
  assign hit_done   = (state_q == HIT) && (hit_cnt_q == HW'(HIT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge) state_d = RUN;
      RUN:     if (collision)  state_d = HIT;
      HIT:     if (hit_done)   state_d = OVER;
      OVER:    if (start_edge) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the divider, hit timer, pass count, speed and animation phase.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    pass_d     = pass_q;
    speed_d    = speed_q;
    anim_d     = anim_q;
    case (state_q)
      IDLE, OVER: begin
        if (restart) begin
          tick_cnt_d = '0;
          pass_d     = '0;
          speed_d    = SPEED_INIT_V;
        end
      end
      RUN: begin
        if (!collision) begin
          tick_cnt_d = tick_fire ? '0 : tick_cnt_q + TW'(1);
        end else begin
          hit_cnt_d = '0;
        end
        if (tick_fire) anim_d = anim_q + 2'd1;
        if (obstacle_wrap) begin
          if (pass_q == PW'(PASS_PER_LEVEL - 1)) begin
            pass_d  = '0;
            speed_d = (speed_q < SPEED_MAX_V) ? speed_q + SPEED_W'(1) : SPEED_MAX_V;
          end else begin
            pass_d = pass_q + PW'(1);
          end
        end
      end
      HIT: begin
        hit_cnt_d = hit_done ? '0 : hit_cnt_q + HW'(1);
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_q      <= 1'b0;
      tick_cnt_q <= '0;
      hit_cnt_q  <= '0;
      pass_q     <= '0;
      speed_q    <= SPEED_INIT_V;
      anim_q     <= 2'd0;
      tick_q     <= 1'b0;
      clr_q      <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      btn_q      <= btn_start;
      tick_cnt_q <= tick_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      pass_q     <= pass_d;
      speed_q    <= speed_d;
      anim_q     <= anim_d;
      tick_q     <= tick_fire;
      clr_q      <= restart;
      over_q     <= (state_d == OVER);
    end
  end

  dino_bcd_counter #(
    .DIGITS(SCORE_DIGITS)
  ) u_score (
    .clk   (clk),
    .reset (reset),
    .clear (restart),
    .inc   (tick_fire),
    .value (score_bcd)
  );

  assign tick            = tick_q;
  assign speed           = speed_q;
  assign anim_phase      = anim_q;
  assign state           = state_q;
  assign game_over       = over_q;
  assign clear_obstacles = clr_q;

endmodule
